shared_mac_scheduler: RTL and testbench
=======================================

Name: shared_mac_scheduler

Overview:
- Owns the single shared signed multiply-add datapath used in normal operation by the altitude and battery computations, and schedules requests onto it.
- Altitude result: x1*K1 + x2*K2, computed in two multiplier passes. Battery result: v*t + c, computed in one pass.
- Arbitrates between the two requesters with round-robin and valid/ready handshakes.
- Accepts new work only while the BIST block's enable_normal is high.

Parameters:
- W, 8, signed operand width.
- RW, 16, signed result/accumulator width.
- ALT_K1, 3, altitude coefficient applied to x1.
- ALT_K2, 5, altitude coefficient applied to x2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_normal  in  1  from BIST; high permits new request acceptance.
- alt_req_valid  in  1  altitude request valid.
- alt_req_ready  out  1  altitude request accepted this cycle when valid&ready.
- alt_x1  in  W  signed altitude operand 1.
- alt_x2  in  W  signed altitude operand 2.
- alt_rsp_valid  out  1  one-cycle pulse; alt_result is valid.
- alt_result  out  RW  signed altitude result.
- bat_req_valid  in  1  battery request valid.
- bat_req_ready  out  1  battery request accepted this cycle when valid&ready.
- bat_v, bat_t, bat_c  in  W each  signed battery operands.
- bat_rsp_valid  out  1  one-cycle pulse; bat_result is valid.
- bat_result  out  RW  signed battery result.
- busy  out  1  high whenever state != IDLE.
- grant_last  out  1  last granted requester: 0 = alt, 1 = bat.

Behaviour:
- Reset (async): state IDLE; acc, alt_result, bat_result = 0; both rsp_valid = 0; busy = 0; grant_last = 1, so alt wins the first tie.
- FSM states: IDLE, ALT_M1, ALT_M2, BAT_M.
- Ready rules: readies are combinational and may be high only in IDLE with enable_normal = 1.
  - alt_req_ready = IDLE & en & (!bat_req_valid | grant_last == 1).
  - bat_req_ready = IDLE & en & (!alt_req_valid | grant_last == 0).
  - Never both high while both valids are high.
- Accept edge: operands are captured into internal registers and grant_last is updated.
  - Alt accept: IDLE -> ALT_M1.
  - Bat accept: IDLE -> BAT_M.
- ALT_M1 edge: acc <= sext(x1*ALT_K1); -> ALT_M2.
- ALT_M2 edge: alt_result <= acc + sext(x2*ALT_K2); alt_rsp_valid <= 1; -> IDLE.
- BAT_M edge: bat_result <= sext(v*t) + sext(c); bat_rsp_valid <= 1; -> IDLE.
- Latency from accept edge to rsp_valid high: alt = 2 cycles, bat = 1 cycle.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high, since state is already IDLE.
- rsp_valid is high for exactly one cycle. Results hold their last value until overwritten.
- Exactly one product is formed per cycle through one multiplier instance. Operand muxing is selected by state.
- Arithmetic:
  - Full-precision 2W product, sign-extended to RW.
  - Sums wrap modulo 2^RW; no saturation. No overflow is possible at defaults.
- enable_normal falling mid-operation: the in-flight operation completes and its response is issued; no further accepts.
- Requester drops valid without ready: nothing happens, no state change.
- Reset mid-operation: in-flight work is discarded, no response pulse, state IDLE.

Decomposition:
- Package shared_mac_pkg holds:
  - state enum (IDLE, ALT_M1, ALT_M2, BAT_M);
  - default W/RW;
  - ALT_K1/ALT_K2 constants;
  - grant encoding constants GRANT_ALT = 0, GRANT_BAT = 1.
- Sub-module shared_mac_dp: combinational signed a*b + addend, one instance. The controller drives its operand-select muxes.

Test Plan:
1. Alt only: en = 1, alt x1 = 2, x2 = 3 -> alt_result = 21; alt_rsp_valid pulses 2 cycles after accept, for one cycle.
2. Bat only: v = -4, t = 2, c = 5 -> bat_result = -3; bat_rsp_valid pulses 1 cycle after accept.
3. Both valid from reset, held:
   - alt (2,3) is served first -> 21;
   - then bat (-4,2,5) -> -3;
   - on the next simultaneous pair, bat wins; grant_last alternates 0,1,0,...
4. en = 0 with both valids held for 5 cycles -> readies stay 0, no rsp, busy = 0. Raising en -> the alt request is accepted the same cycle.
5. Reset pulse while in ALT_M2 -> alt_rsp_valid never pulses, all outputs 0, IDLE. A subsequent alt (2,3) still yields 21.
6. Extremes:
   - bat v = -128, t = -128, c = 127 -> 16511;
   - alt x1 = -128, x2 = 127 -> 251;
   - back-to-back accepts with no idle gap.

Source files
------------

// File: rtl/shared_mac_scheduler_pkg.sv
// rtl/shared_mac_scheduler_pkg.sv - shared MAC scheduler types, defaults and grant encoding
package shared_mac_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_RW     = 16;
    localparam int DEF_ALT_K1 = 3;
    localparam int DEF_ALT_K2 = 5;

    localparam logic GRANT_ALT = 1'b0;
    localparam logic GRANT_BAT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALT_M1 = 2'd1,
        ALT_M2 = 2'd2,
        BAT_M  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/shared_mac_scheduler_if.sv
// rtl/shared_mac_scheduler_if.sv - request/response and status bundle for the shared MAC scheduler
interface shared_mac_scheduler_if #(
    parameter int W  = 8,
    parameter int RW = 16
);
    logic                 alt_req_valid;
    logic                 alt_req_ready;
    logic signed [W-1:0]  alt_x1;
    logic signed [W-1:0]  alt_x2;
    logic                 alt_rsp_valid;
    logic signed [RW-1:0] alt_result;

    logic                 bat_req_valid;
    logic                 bat_req_ready;
    logic signed [W-1:0]  bat_v;
    logic signed [W-1:0]  bat_t;
    logic signed [W-1:0]  bat_c;
    logic                 bat_rsp_valid;
    logic signed [RW-1:0] bat_result;

    logic                 busy;
    logic                 grant_last;

    modport master (
        output alt_req_valid, alt_x1, alt_x2,
        output bat_req_valid, bat_v, bat_t, bat_c,
        input  alt_req_ready, alt_rsp_valid, alt_result,
        input  bat_req_ready, bat_rsp_valid, bat_result,
        input  busy, grant_last
    );

    modport slave (
        input  alt_req_valid, alt_x1, alt_x2,
        input  bat_req_valid, bat_v, bat_t, bat_c,
        output alt_req_ready, alt_rsp_valid, alt_result,
        output bat_req_ready, bat_rsp_valid, bat_result,
        output busy, grant_last
    );

endinterface

// File: rtl/shared_mac_scheduler_dp.sv
// rtl/shared_mac_scheduler_dp.sv - single shared signed multiply-add: y = sext(a*b) + addend
module shared_mac_dp #(
    parameter int W  = 8,
    parameter int RW = 16
) (
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    input  logic signed [RW-1:0] addend,
    output logic signed [RW-1:0] y
);

    logic signed [2*W-1:0] prod;

    assign prod = a * b;
    assign y    = RW'(prod) + addend;

endmodule

// File: rtl/shared_mac_scheduler.sv
// rtl/shared_mac_scheduler.sv - round-robin scheduler for altitude/battery work on one shared MAC
module shared_mac_scheduler
    import shared_mac_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int RW     = DEF_RW,
    parameter int ALT_K1 = DEF_ALT_K1,
    parameter int ALT_K2 = DEF_ALT_K2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_normal,
    shared_mac_scheduler_if.slave  bus
);

    localparam logic signed [W-1:0] K1_W = W'(ALT_K1);
    localparam logic signed [W-1:0] K2_W = W'(ALT_K2);

    mac_state_t state_q;
    mac_state_t state_d;

    logic signed [W-1:0]  x1_q;
    logic signed [W-1:0]  x2_q;
    logic signed [W-1:0]  v_q;
    logic signed [W-1:0]  t_q;
    logic signed [W-1:0]  c_q;
    logic signed [RW-1:0] acc_q;
    logic signed [RW-1:0] alt_res_q;
    logic signed [RW-1:0] bat_res_q;
    logic                 alt_rv_q;
    logic                 bat_rv_q;
    logic                 grant_q;

    logic                 idle;
    logic                 alt_ready;
    logic                 bat_ready;
    logic                 alt_fire;
    logic                 bat_fire;

    logic signed [W-1:0]  mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [RW-1:0] mul_add;
    logic signed [RW-1:0] mac_y;

    // On a tie the requester that was not granted last wins.
    assign idle      = (state_q == IDLE);
    assign alt_ready = idle && enable_normal && (!bus.bat_req_valid || grant_q == GRANT_BAT);
    assign bat_ready = idle && enable_normal && (!bus.alt_req_valid || grant_q == GRANT_ALT);
    assign alt_fire  = alt_ready && bus.alt_req_valid;
    assign bat_fire  = bat_ready && bus.bat_req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (alt_fire) begin
                    state_d = ALT_M1;
                end else if (bat_fire) begin
                    state_d = BAT_M;
                end
            end
            ALT_M1:  state_d = ALT_M2;
            ALT_M2:  state_d = IDLE;
            BAT_M:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand steering for the one multiplier, chosen by the current phase.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        mul_add = '0;
        case (state_q)
            ALT_M1: begin
                mul_a = x1_q;
                mul_b = K1_W;
            end
            ALT_M2: begin
                mul_a   = x2_q;
                mul_b   = K2_W;
                mul_add = acc_q;
            end
            BAT_M: begin
                mul_a   = v_q;
                mul_b   = t_q;
                mul_add = RW'(c_q);
            end
            default: begin
                mul_a   = '0;
                mul_b   = '0;
                mul_add = '0;
            end
        endcase
    end

    shared_mac_dp #(
        .W  (W),
        .RW (RW)
    ) u_dp (
        .a      (mul_a),
        .b      (mul_b),
        .addend (mul_add),
        .y      (mac_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1_q      <= '0;
            x2_q      <= '0;
            v_q       <= '0;
            t_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            alt_res_q <= '0;
            bat_res_q <= '0;
            alt_rv_q  <= 1'b0;
            bat_rv_q  <= 1'b0;
            grant_q   <= GRANT_BAT;
        end else begin
            alt_rv_q <= 1'b0;
            bat_rv_q <= 1'b0;
            if (alt_fire) begin
                x1_q    <= bus.alt_x1;
                x2_q    <= bus.alt_x2;
                grant_q <= GRANT_ALT;
            end else if (bat_fire) begin
                v_q     <= bus.bat_v;
                t_q     <= bus.bat_t;
                c_q     <= bus.bat_c;
                grant_q <= GRANT_BAT;
            end
            case (state_q)
                ALT_M1: acc_q <= mac_y;
                ALT_M2: begin
                    alt_res_q <= mac_y;
                    alt_rv_q  <= 1'b1;
                end
                BAT_M: begin
                    bat_res_q <= mac_y;
                    bat_rv_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.alt_req_ready = alt_ready;
    assign bus.bat_req_ready = bat_ready;
    assign bus.alt_rsp_valid = alt_rv_q;
    assign bus.bat_rsp_valid = bat_rv_q;
    assign bus.alt_result    = alt_res_q;
    assign bus.bat_result    = bat_res_q;
    assign bus.busy          = !idle;
    assign bus.grant_last    = grant_q;

endmodule

// File: tb/tb_shared_mac_scheduler.sv
// tb/tb_shared_mac_scheduler.sv - self-checking bench with behavioural model for shared_mac_scheduler
module tb_shared_mac_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable_normal = 1'b0;

    always #5 clk = ~clk;

    shared_mac_scheduler_if #(.W(8), .RW(16)) bus ();

    shared_mac_scheduler #(
        .W      (8),
        .RW     (16),
        .ALT_K1 (3),
        .ALT_K2 (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_normal (enable_normal),
        .bus           (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: a job occupies the MAC for a fixed number of edges after it is
    // accepted; its result is computed arithmetically at acceptance time.
    int m_left    = 0;
    bit m_is_alt  = 1'b0;
    int m_pend    = 0;
    int m_alt_res = 0;
    int m_bat_res = 0;
    bit m_alt_rv  = 1'b0;
    bit m_bat_rv  = 1'b0;
    bit m_gl      = 1'b1;

    function automatic int wrap16(input int x);
        logic signed [15:0] s;
        s = x[15:0];
        return int'(s);
    endfunction

    function automatic bit m_alt_ready();
        return (m_left == 0) && enable_normal && (!bus.bat_req_valid || m_gl);
    endfunction

    function automatic bit m_bat_ready();
        return (m_left == 0) && enable_normal && (!bus.alt_req_valid || !m_gl);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left    = 0;
            m_alt_res = 0;
            m_bat_res = 0;
            m_alt_rv  = 1'b0;
            m_bat_rv  = 1'b0;
            m_gl      = 1'b1;
        end else begin
            bit ar;
            bit br;
            ar = m_alt_ready() && bus.alt_req_valid;
            br = m_bat_ready() && bus.bat_req_valid;
            m_alt_rv = 1'b0;
            m_bat_rv = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_is_alt) begin
                        m_alt_res = m_pend;
                        m_alt_rv  = 1'b1;
                    end else begin
                        m_bat_res = m_pend;
                        m_bat_rv  = 1'b1;
                    end
                end
            end else if (ar) begin
                m_pend   = wrap16(int'(bus.alt_x1) * 3 + int'(bus.alt_x2) * 5);
                m_is_alt = 1'b1;
                m_left   = 2;
                m_gl     = 1'b0;
            end else if (br) begin
                m_pend   = wrap16(int'(bus.bat_v) * int'(bus.bat_t) + int'(bus.bat_c));
                m_is_alt = 1'b0;
                m_left   = 1;
                m_gl     = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("alt_req_ready", int'(bus.alt_req_ready), int'(m_alt_ready()));
        check("bat_req_ready", int'(bus.bat_req_ready), int'(m_bat_ready()));
        check("alt_rsp_valid", int'(bus.alt_rsp_valid), int'(m_alt_rv));
        check("bat_rsp_valid", int'(bus.bat_rsp_valid), int'(m_bat_rv));
        check("alt_result", int'(bus.alt_result), m_alt_res);
        check("bat_result", int'(bus.bat_result), m_bat_res);
        check("busy", int'(bus.busy), int'(m_left != 0));
        check("grant_last", int'(bus.grant_last), int'(m_gl));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        bus.alt_req_valid = 1'b0;
        bus.bat_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_alt(input int x1, input int x2, input int exp);
        bus.alt_x1 = 8'(x1);
        bus.alt_x2 = 8'(x2);
        bus.alt_req_valid = 1'b1;
        #1 check("lit_alt_ready", int'(bus.alt_req_ready), 1);
        step();
        bus.alt_req_valid = 1'b0;
        #1 check("lit_alt_rsp_m1", int'(bus.alt_rsp_valid), 0);
        step();
        #1 check("lit_alt_rsp_m2", int'(bus.alt_rsp_valid), 0);
        step();
        #1 check("lit_alt_rsp", int'(bus.alt_rsp_valid), 1);
        check("lit_alt_result", int'(bus.alt_result), exp);
        step();
        #1 check("lit_alt_rsp_drop", int'(bus.alt_rsp_valid), 0);
        check("lit_alt_hold", int'(bus.alt_result), exp);
    endtask

    task automatic run_bat(input int v, input int t, input int c, input int exp);
        bus.bat_v = 8'(v);
        bus.bat_t = 8'(t);
        bus.bat_c = 8'(c);
        bus.bat_req_valid = 1'b1;
        step();
        bus.bat_req_valid = 1'b0;
        #1 check("lit_bat_rsp_m", int'(bus.bat_rsp_valid), 0);
        step();
        #1 check("lit_bat_rsp", int'(bus.bat_rsp_valid), 1);
        check("lit_bat_result", int'(bus.bat_result), exp);
        step();
        #1 check("lit_bat_rsp_drop", int'(bus.bat_rsp_valid), 0);
    endtask

    initial begin
        quiet();
        bus.alt_x1 = '0;
        bus.alt_x2 = '0;
        bus.bat_v  = '0;
        bus.bat_t  = '0;
        bus.bat_c  = '0;
        step();
        step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_alt_result", int'(bus.alt_result), 0);
        check("rst_bat_result", int'(bus.bat_result), 0);
        check("rst_grant_last", int'(bus.grant_last), 1);
        reset = 1'b0;
        enable_normal = 1'b1;
        step();

        run_alt(2, 3, 21);
        run_bat(-4, 2, 5, -3);

        // Both requesters held from reset: alt first, then bat.
        do_reset();
        bus.alt_x1 = 8'sd2;
        bus.alt_x2 = 8'sd3;
        bus.bat_v  = -8'sd4;
        bus.bat_t  = 8'sd2;
        bus.bat_c  = 8'sd5;
        bus.alt_req_valid = 1'b1;
        bus.bat_req_valid = 1'b1;
        #1 check("tie_alt_first", int'(bus.alt_req_ready), 1);
        check("tie_bat_blocked", int'(bus.bat_req_ready), 0);
        step();
        check("tie_gl_alt", int'(bus.grant_last), 0);
        step();
        step();
        #1 check("tie_alt_result", int'(bus.alt_result), 21);
        check("tie_bat_turn", int'(bus.bat_req_ready), 1);
        step();
        check("tie_gl_bat", int'(bus.grant_last), 1);
        step();
        #1 check("tie_bat_result", int'(bus.bat_result), -3);
        repeat (8) step();
        quiet();
        repeat (3) step();

        // Gated by BIST: nothing moves while enable_normal is low.
        do_reset();
        enable_normal = 1'b0;
        bus.alt_req_valid = 1'b1;
        bus.bat_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("en0_alt_ready", int'(bus.alt_req_ready), 0);
            check("en0_bat_ready", int'(bus.bat_req_ready), 0);
            check("en0_busy", int'(bus.busy), 0);
            step();
        end
        enable_normal = 1'b1;
        #1 check("en1_alt_ready", int'(bus.alt_req_ready), 1);
        step();
        quiet();
        repeat (3) step();

        // Reset while in ALT_M2 discards the job.
        bus.alt_x1 = 8'sd2;
        bus.alt_x2 = 8'sd3;
        bus.alt_req_valid = 1'b1;
        step();
        bus.alt_req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1 check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_alt_result", int'(bus.alt_result), 0);
        step();
        check("mid_rst_no_rsp", int'(bus.alt_rsp_valid), 0);
        reset = 1'b0;
        step();
        check("post_rst_no_rsp", int'(bus.alt_rsp_valid), 0);
        run_alt(2, 3, 21);

        run_bat(-128, -128, 127, 16511);
        run_alt(-128, 127, 251);

        // Back-to-back alt: next request accepted in the response cycle.
        bus.alt_x1 = 8'sd1;
        bus.alt_x2 = 8'sd1;
        bus.alt_req_valid = 1'b1;
        step();
        step();
        step();
        #1 check("b2b_rsp", int'(bus.alt_rsp_valid), 1);
        check("b2b_result", int'(bus.alt_result), 8);
        check("b2b_ready", int'(bus.alt_req_ready), 1);
        bus.alt_x1 = 8'sd4;
        bus.alt_x2 = -8'sd2;
        step();
        #1 check("b2b_busy", int'(bus.busy), 1);
        bus.alt_req_valid = 1'b0;
        step();
        step();
        #1 check("b2b_result2", int'(bus.alt_result), 2);
        repeat (3) step();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            bus.alt_req_valid = 1'($urandom);
            bus.bat_req_valid = 1'($urandom);
            bus.alt_x1 = 8'($urandom);
            bus.alt_x2 = 8'($urandom);
            bus.bat_v  = 8'($urandom);
            bus.bat_t  = 8'($urandom);
            bus.bat_c  = 8'($urandom);
            enable_normal = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        quiet();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
